core_ctrl: RTL and testbench

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_core_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// core_ctrl: sequences Q/K memory loads, K feed, gap, Q execute,
// output-FIFO accumulate and normalise/write-back for one attention run.
// The instruction word is registered; it reflects the state and counter of
// the previous cycle.
module core_ctrl #(
    parameter int ROWS = 8,
    parameter int GAP  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic        ofifo_valid,
    output logic [19:0] inst,
    output logic        in_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        QLOAD,
        KLOAD,
        KFEED,
        GAPW,
        QEXEC,
        ACC,
        NORM
    } state_t;

    localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    localparam int B_SFP_WR = 19;
    localparam int B_ACC    = 18;
    localparam int B_DIV    = 17;
    localparam int B_OFIFO  = 16;
    localparam int B_EXEC   = 7;
    localparam int B_LOAD   = 6;
    localparam int B_QRD    = 5;
    localparam int B_QWR    = 4;
    localparam int B_KRD    = 3;
    localparam int B_KWR    = 2;
    localparam int B_PWR    = 0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;   // ACC: all ROWS ofifo reads issued
    logic        pend_q, pend_d;   // ACC: an acc is owed for last cycle's read
    logic        fin_q, fin_d;     // NORM finished; delays done by one cycle
    logic [19:0] inst_q, inst_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state, counter and instruction decode from the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        pend_d  = 1'b0;
        fin_d   = 1'b0;
        inst_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = QLOAD;
                    cnt_d   = '0;
                end
            end
            QLOAD: begin
                if (in_valid) begin
                    inst_d[B_QWR]  = 1'b1;
                    inst_d[15:12]  = cnt_q;
                    if (cnt_q == ROW_LAST) begin
                        state_d = KLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            KLOAD: begin
                if (in_valid) begin
                    inst_d[B_KWR]  = 1'b1;
                    inst_d[15:12]  = cnt_q;
                    if (cnt_q == ROW_LAST) begin
                        state_d = KFEED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            KFEED: begin
                inst_d[B_KRD]  = 1'b1;
                inst_d[B_LOAD] = 1'b1;
                inst_d[15:12]  = cnt_q;
                if (cnt_q == ROW_LAST) begin
                    state_d = GAPW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAPW: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = QEXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            QEXEC: begin
                inst_d[B_QRD]  = 1'b1;
                inst_d[B_EXEC] = 1'b1;
                inst_d[15:12]  = cnt_q;
                if (cnt_q == ROW_LAST) begin
                    state_d = ACC;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACC: begin
                inst_d[B_ACC] = pend_q;
                // cnt stops at ROWS-1 so ROWS=16 fits in 4 bits; last_q marks
                // that the final read has gone out.
                if (pend_q && last_q) begin
                    state_d = NORM;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end else if (ofifo_valid && !last_q) begin
                    inst_d[B_OFIFO] = 1'b1;
                    pend_d          = 1'b1;
                    if (cnt_q == ROW_LAST) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            NORM: begin
                inst_d[B_DIV]    = 1'b1;
                inst_d[B_PWR]    = 1'b1;
                inst_d[B_SFP_WR] = 1'b1;
                inst_d[11:8]     = cnt_q;
                if (cnt_q == ROW_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fin_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        in_ready_d = (state_d == QLOAD) || (state_d == KLOAD);
        busy_d     = (state_d != IDLE);
        done_d     = fin_q;
    end

    // State, counter and registered outputs; async active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            pend_q     <= 1'b0;
            fin_q      <= 1'b0;
            inst_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            fin_q      <= fin_d;
            inst_q     <= inst_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst     = inst_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: two instances (ROWS=8/GAP=8 and ROWS=16/GAP=3) share
// start/in_valid/ofifo_valid; each has its own reset. A run-level model
// expands every accepted start into the expected per-cycle output timeline.
module tb_core_ctrl;

    localparam int N  = 600;
    localparam int NW = 520;

    localparam logic [19:0] I_SFP  = 20'h80000;
    localparam logic [19:0] I_ACC  = 20'h40000;
    localparam logic [19:0] I_DIV  = 20'h20000;
    localparam logic [19:0] I_ORD  = 20'h10000;
    localparam logic [19:0] I_EXE  = 20'h00080;
    localparam logic [19:0] I_LOAD = 20'h00040;
    localparam logic [19:0] I_QRD  = 20'h00020;
    localparam logic [19:0] I_QWR  = 20'h00010;
    localparam logic [19:0] I_KRD  = 20'h00008;
    localparam logic [19:0] I_KWR  = 20'h00004;
    localparam logic [19:0] I_PWR  = 20'h00001;

    logic        clk;
    logic        rst_a, rst_b;
    logic        start, in_valid, ofifo_valid;
    logic [19:0] inst_a, inst_b;
    logic        rdy_a, rdy_b, busy_a, busy_b, done_a, done_b;

    int checks;
    int errors;

    // Stimulus per clock edge index; reset per window (after that edge).
    bit st[N];
    bit iv[N];
    bit ov[N];
    bit rl[2][N];

    // Expected outputs per window.
    logic [19:0] ei[2][N];
    bit          eb[2][N];
    bit          er[2][N];
    bit          ed[2][N];

    core_ctrl #(.ROWS(8), .GAP(8)) u_a (
        .clk(clk), .reset(rst_a), .start(start), .in_valid(in_valid),
        .ofifo_valid(ofifo_valid), .inst(inst_a), .in_ready(rdy_a),
        .busy(busy_a), .done(done_a)
    );

    core_ctrl #(.ROWS(16), .GAP(3)) u_b (
        .clk(clk), .reset(rst_b), .start(start), .in_valid(in_valid),
        .ofifo_valid(ofifo_valid), .inst(inst_b), .in_ready(rdy_b),
        .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] qk_addr(input int n);
        return 20'(n) << 12;
    endfunction

    function automatic logic [19:0] pm_addr(input int n);
        return 20'(n) << 8;
    endfunction

    // One run accepted at edge k; returns the first edge at which a new start
    // can be taken.
    task automatic build(input int d, input int rows, input int gap,
                         input int k, output int ee);
        int e;
        int reads;
        bit pend;
        bit wrote;
        logic [19:0] w;
        e = k + 1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < rows; n++) begin
                wrote = 1'b0;
                while (!wrote && e < N - 1) begin
                    eb[d][e-1] = 1'b1;
                    er[d][e-1] = 1'b1;
                    if (iv[e]) begin
                        ei[d][e] = (ph == 0 ? I_QWR : I_KWR) | qk_addr(n);
                        wrote = 1'b1;
                    end
                    e++;
                end
            end
        end
        for (int n = 0; n < rows && e < N - 1; n++) begin
            eb[d][e-1] = 1'b1;
            ei[d][e] = I_KRD | I_LOAD | qk_addr(n);
            e++;
        end
        for (int g = 0; g < gap && e < N - 1; g++) begin
            eb[d][e-1] = 1'b1;
            e++;
        end
        for (int n = 0; n < rows && e < N - 1; n++) begin
            eb[d][e-1] = 1'b1;
            ei[d][e] = I_QRD | I_EXE | qk_addr(n);
            e++;
        end
        reads = 0;
        pend  = 1'b0;
        while (e < N - 1) begin
            eb[d][e-1] = 1'b1;
            w = pend ? I_ACC : 20'h0;
            if (reads == rows && pend) begin
                ei[d][e] = w;
                e++;
                break;
            end
            if (ov[e] && reads < rows) begin
                w = w | I_ORD;
                reads++;
                pend = 1'b1;
            end else begin
                pend = 1'b0;
            end
            ei[d][e] = w;
            e++;
        end
        for (int n = 0; n < rows && e < N - 1; n++) begin
            eb[d][e-1] = 1'b1;
            ei[d][e] = I_SFP | I_DIV | I_PWR | pm_addr(n);
            e++;
        end
        ed[d][e] = 1'b1;
        ee = e;
    endtask

    // Walk the edges: take starts only when idle, and wipe any run a reset
    // cuts short from the reset window onward.
    task automatic run_model(input int d, input int rows, input int gap);
        int e;
        int ee;
        int m;
        bit hit;
        e = 1;
        while (e < N - 1) begin
            if (rl[d][e-1]) begin
                e++;
                continue;
            end
            if (st[e]) begin
                build(d, rows, gap, e, ee);
                hit = 1'b0;
                m = ee;
                for (int j = e; j <= ee; j++) begin
                    if (!hit && rl[d][j]) begin
                        hit = 1'b1;
                        m = j;
                    end
                end
                if (hit) begin
                    for (int j = m; j <= ee; j++) begin
                        ei[d][j] = '0;
                        eb[d][j] = 1'b0;
                        er[d][j] = 1'b0;
                        ed[d][j] = 1'b0;
                    end
                    e = m + 1;
                end else begin
                    e = ee;
                end
            end else begin
                e++;
            end
        end
    endtask

    task automatic cmp(input string nm, input int w, input logic [19:0] act,
                       input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s window=%0d got=%h want=%h", nm, w, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < N; i++) begin
            st[i] = 1'b0;
            iv[i] = 1'b1;
            ov[i] = 1'b1;
            for (int d = 0; d < 2; d++) begin
                rl[d][i] = 1'b0;
                ei[d][i] = '0;
                eb[d][i] = 1'b0;
                er[d][i] = 1'b0;
                ed[d][i] = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            rl[0][i] = 1'b1;
            rl[1][i] = 1'b1;
        end
        // run 1: in_valid toggles 1,0,1,0,... early in the load
        st[4] = 1'b1;
        for (int i = 6; i <= 12; i += 2) iv[i] = 1'b0;
        // run 2: 20-cycle ofifo_valid stall inside the 8-row ACC phase
        st[130] = 1'b1;
        for (int i = 171; i <= 190; i++) ov[i] = 1'b0;
        // run 3: 8-row instance reset while executing row 3
        st[260] = 1'b1;
        for (int i = 295; i <= 298; i++) rl[0][i] = 1'b1;
        // start held high across a whole run
        for (int i = 320; i <= 420; i++) st[i] = 1'b1;

        run_model(0, 8, 8);
        run_model(1, 16, 3);

        rst_a       = 1'b0;
        rst_b       = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        ofifo_valid = 1'b0;

        fork
            begin
                for (int w = 0; w < NW; w++) begin
                    @(posedge clk);
                    #1;
                    rst_a       = !rl[0][w];
                    rst_b       = !rl[1][w];
                    start       = st[w+1];
                    in_valid    = iv[w+1];
                    ofifo_valid = ov[w+1];
                end
            end
            begin
                for (int w = 0; w < NW; w++) begin
                    @(negedge clk);
                    cmp("inst_a", w, inst_a, ei[0][w]);
                    cmp("busy_a", w, 20'(busy_a), 20'(eb[0][w]));
                    cmp("rdy_a",  w, 20'(rdy_a),  20'(er[0][w]));
                    cmp("done_a", w, 20'(done_a), 20'(ed[0][w]));
                    cmp("inst_b", w, inst_b, ei[1][w]);
                    cmp("busy_b", w, 20'(busy_b), 20'(eb[1][w]));
                    cmp("rdy_b",  w, 20'(rdy_b),  20'(er[1][w]));
                    cmp("done_b", w, 20'(done_b), 20'(ed[1][w]));
                    case (w)
                        1: begin
                            cmp("pin_rst_inst_a", w, inst_a, 20'h00000);
                            cmp("pin_rst_busy_a", w, 20'(busy_a), 20'h0);
                            cmp("pin_rst_rdy_a",  w, 20'(rdy_a),  20'h0);
                            cmp("pin_rst_done_b", w, 20'(done_b), 20'h0);
                        end
                        4:   cmp("pin_qload_rdy_a", w, 20'(rdy_a), 20'h1);
                        11:  cmp("pin_qwr3_a", w, inst_a, 20'h03010);
                        12:  cmp("pin_qhole_a", w, inst_a, 20'h00000);
                        24:  cmp("pin_qwr15_b", w, inst_b, 20'h0F010);
                        65: begin
                            cmp("pin_pwr7_a", w, inst_a, 20'hA0701);
                            cmp("pin_done_early_a", w, 20'(done_a), 20'h0);
                        end
                        66: begin
                            cmp("pin_done_a", w, 20'(done_a), 20'h1);
                            cmp("pin_idle_a", w, 20'(busy_a), 20'h0);
                        end
                        108: cmp("pin_pwr15_b", w, inst_b, 20'hA0F01);
                        109: cmp("pin_done_b", w, 20'(done_b), 20'h1);
                        131: cmp("pin_wrap_b", w, inst_b, 20'h00010);
                        190: begin
                            cmp("pin_stall_inst_a", w, inst_a, 20'h00000);
                            cmp("pin_stall_busy_a", w, 20'(busy_a), 20'h1);
                        end
                        191: cmp("pin_ofrd_a", w, inst_a, 20'h10000);
                        199: cmp("pin_lastacc_a", w, inst_a, 20'h40000);
                        294: cmp("pin_exec1_a", w, inst_a, 20'h010A0);
                        295: cmp("pin_rstrun_a", w, inst_a, 20'h00000);
                        299: cmp("pin_postrst_busy_a", w, 20'(busy_a), 20'h0);
                        300: cmp("pin_postrst_inst_a", w, inst_a, 20'h00000);
                        378: begin
                            cmp("pin_held_done_a", w, 20'(done_a), 20'h1);
                            cmp("pin_held_rerun_a", w, 20'(busy_a), 20'h1);
                        end
                        440: cmp("pin_held_single_a", w, 20'(busy_a), 20'h0);
                        default: ;
                    endcase
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
